// File: rtl/frame_ctl_regs.sv
// Frame-synchronous control register bank: NUM_CH staging registers copied atomically to active at vblank start.
// Optional macro FRAME_CTL_EDGE_EN adds per-channel trig_pulse on a 0->1 commit of bit TRIG_BIT.
module frame_ctl_regs #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 32,
  parameter int FRAME_CNT_W = 16,
  parameter int TRIG_BIT    = 21,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     commit_req,
  input  logic [CH_W-1:0]          rd_ch,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     VGA_VS,
  output logic [NUM_CH*DATA_W-1:0] ctl_out,
  output logic                     commit_pending,
  output logic                     commit_done,
  output logic [FRAME_CNT_W-1:0]   frame_count
`ifdef FRAME_CTL_EDGE_EN
  ,output logic [NUM_CH-1:0]       trig_pulse
`endif
);

  localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(NUM_CH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [DATA_W-1:0]        r_staging [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] r_active;
  logic                     r_vs_s1;
  logic                     r_vs_s2;
  logic                     r_vs_d;
  logic                     r_done;
  logic [DATA_W-1:0]        r_rd;
  logic [FRAME_CNT_W-1:0]   r_frame;
  logic                     w_vblank_edge;
  logic                     w_wr_ok;
  logic                     w_rd_ok;
  logic                     w_commit;

  assign w_vblank_edge = r_vs_d & ~r_vs_s2;
  assign w_wr_ok       = wr_en & ({1'b0, wr_ch} < CH_LIM);
  assign w_rd_ok       = ({1'b0, rd_ch} < CH_LIM);
  assign w_commit      = (r_state == ST_COMMIT);

  // VGA_VS is asynchronous: two sync flops plus a delay flop for falling-edge detection
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_vs_s1 <= 1'b0;
      r_vs_s2 <= 1'b0;
      r_vs_d  <= 1'b0;
    end else begin
      r_vs_s1 <= VGA_VS;
      r_vs_s2 <= r_vs_s1;
      r_vs_d  <= r_vs_s2;
    end
  end

  // Commit FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Commit FSM next state; an edge coinciding with the request in IDLE is deliberately skipped
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (commit_req) w_state_nxt = ST_PENDING;
        else            w_state_nxt = ST_IDLE;
      end
      ST_PENDING: begin
        if (w_vblank_edge) w_state_nxt = ST_COMMIT;
        else               w_state_nxt = ST_PENDING;
      end
      ST_COMMIT: begin
        if (commit_req) w_state_nxt = ST_PENDING;
        else            w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Staging registers, writable in every state
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int c = 0; c < NUM_CH; c++) r_staging[c] <= {DATA_W{1'b0}};
    end else if (w_wr_ok) begin
      r_staging[wr_ch] <= wr_data;
    end
  end

  // Active copy takes pre-write staging values during the commit cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_active <= {(NUM_CH*DATA_W){1'b0}};
      r_done   <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_commit) begin
        for (int c = 0; c < NUM_CH; c++) r_active[c*DATA_W +: DATA_W] <= r_staging[c];
      end
    end
  end

  // Registered staging readback and frame counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rd    <= {DATA_W{1'b0}};
      r_frame <= {FRAME_CNT_W{1'b0}};
    end else begin
      r_rd <= w_rd_ok ? r_staging[rd_ch] : {DATA_W{1'b0}};
      if (w_vblank_edge) r_frame <= r_frame + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign rd_data        = r_rd;
  assign ctl_out        = r_active;
  assign commit_done    = r_done;
  assign frame_count    = r_frame;
  assign commit_pending = (r_state == ST_PENDING) || w_commit;

`ifdef FRAME_CTL_EDGE_EN
  logic [NUM_CH-1:0] r_trig_arm;
  logic [NUM_CH-1:0] r_trig;

  // Arm on the commit cycle, pulse one cycle later so trig aligns with the cycle after commit_done
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_trig_arm <= {NUM_CH{1'b0}};
      r_trig     <= {NUM_CH{1'b0}};
    end else begin
      r_trig <= r_trig_arm;
      for (int c = 0; c < NUM_CH; c++) begin
        r_trig_arm[c] <= w_commit & ~r_active[c*DATA_W+TRIG_BIT] & r_staging[c][TRIG_BIT];
      end
    end
  end

  assign trig_pulse = r_trig;
`else
  logic w_unused_trig;
  assign w_unused_trig = (TRIG_BIT >= DATA_W);
`endif

endmodule

// File: tb/tb_frame_ctl_regs.sv
// Randomised self-checking bench for frame_ctl_regs against a flag-level behavioural model.
// Build with FRAME_CTL_EDGE_EN defined to also cover trig_pulse.
module tb_frame_ctl_regs;
  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 32;
  localparam int FW       = 16;
  localparam int CH_W     = 2;
  localparam int TRIG_BIT = 21;

  logic                     Clk = 1'b0;
  logic                     Reset = 1'b1;
  logic                     wr_en = 1'b0;
  logic [CH_W-1:0]          wr_ch = '0;
  logic [DATA_W-1:0]        wr_data = '0;
  logic                     commit_req = 1'b0;
  logic [CH_W-1:0]          rd_ch = '0;
  logic                     VGA_VS = 1'b1;
  logic [DATA_W-1:0]        rd_data;
  logic [NUM_CH*DATA_W-1:0] ctl_out;
  logic                     commit_pending;
  logic                     commit_done;
  logic [FW-1:0]            frame_count;
`ifdef FRAME_CTL_EDGE_EN
  logic [NUM_CH-1:0]        trig_pulse;
`endif

  int checks = 0;
  int errors = 0;

  always #10 Clk = ~Clk;

  frame_ctl_regs #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_CNT_W(FW), .TRIG_BIT(TRIG_BIT)) dut (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .commit_req(commit_req), .rd_ch(rd_ch), .rd_data(rd_data), .VGA_VS(VGA_VS),
    .ctl_out(ctl_out), .commit_pending(commit_pending), .commit_done(commit_done),
    .frame_count(frame_count)
`ifdef FRAME_CTL_EDGE_EN
    , .trig_pulse(trig_pulse)
`endif
  );

  // Reference model state
  logic [DATA_W-1:0] m_stg [NUM_CH];
  logic [DATA_W-1:0] m_act [NUM_CH];
  bit                m_pend;
  bit                m_commit_next;
  bit                m_done;
  logic [FW-1:0]     m_frame;
  logic [DATA_W-1:0] m_rd;
  logic [NUM_CH-1:0] m_arm;
  logic [NUM_CH-1:0] m_trig;
  bit                m_smp[$];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_stg[c] = '0;
      m_act[c] = '0;
    end
    m_pend = 0; m_commit_next = 0; m_done = 0;
    m_frame = '0; m_rd = '0; m_arm = '0; m_trig = '0;
    m_smp = {1'b0, 1'b0, 1'b0};
  endtask

  // One rising edge: vblank seen when VS was sampled high three edges ago and low two edges ago
  task automatic model_tick();
    logic [DATA_W-1:0] pre [NUM_CH];
    bit edge_now;
    edge_now = !m_smp[1] && m_smp[2];
    pre = m_stg;
    m_trig = m_arm;
    m_arm = '0;
    m_done = 0;
    m_rd = (int'(rd_ch) < NUM_CH) ? pre[rd_ch] : '0;
    if (m_commit_next) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_arm[c] = !m_act[c][TRIG_BIT] && pre[c][TRIG_BIT];
        m_act[c] = pre[c];
      end
      m_done = 1;
      m_commit_next = 0;
      m_pend = commit_req;
    end else if (m_pend) begin
      if (edge_now) begin
        m_commit_next = 1;
        m_pend = 0;
      end
    end else if (commit_req) begin
      m_pend = 1;
    end
    if (wr_en && int'(wr_ch) < NUM_CH) m_stg[wr_ch] = wr_data;
    if (edge_now) m_frame = m_frame + 16'd1;
    m_smp.push_front(VGA_VS);
    void'(m_smp.pop_back());
  endtask

  function automatic logic [127:0] model_ctl();
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c*DATA_W +: DATA_W] = m_act[c];
    return r;
  endfunction

  task automatic compare_all();
    check_val("ctl_out", ctl_out, model_ctl());
    check_val("commit_done", commit_done, m_done);
    check_val("commit_pending", commit_pending, m_pend || m_commit_next);
    check_val("frame_count", frame_count, m_frame);
    check_val("rd_data", rd_data, m_rd);
`ifdef FRAME_CTL_EDGE_EN
    check_val("trig_pulse", trig_pulse, m_trig);
`endif
  endtask

  task automatic step();
    @(posedge Clk);
    model_tick();
    #1;
    compare_all();
    @(negedge Clk);
  endtask

  task automatic drive(input bit we, input int ch, input logic [DATA_W-1:0] d, input bit req, input bit vs);
    wr_en = we;
    wr_ch = CH_W'(ch);
    wr_data = d;
    commit_req = req;
    VGA_VS = vs;
  endtask

  task automatic vsync(input int hi_cycles);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, '0, 0, 0);
      step();
    end
    for (int i = 0; i < hi_cycles; i++) begin
      drive(0, 0, '0, 0, 1);
      step();
    end
  endtask

  initial begin
    int lo_left;
    int hi_left;
    int trig_seen;
    repeat (2) @(negedge Clk);
    check_val("rst_ctl", ctl_out, '0);
    check_val("rst_frame", frame_count, '0);
    check_val("rst_rd", rd_data, '0);
    check_val("rst_pending", commit_pending, 1'b0);
    model_reset();
    Reset = 1'b0;
    step();

    // Staged write without commit survives vsyncs untouched in active
    rd_ch = 2'd1;
    drive(1, 1, 32'h1234_5678, 0, 1); step();
    for (int f = 0; f < 3; f++) vsync(6);
    check_val("t2_ch1_active", ctl_out[63:32], 32'h0);
    check_val("t2_rd", rd_data, 32'h1234_5678);
    check_val("t2_frames", frame_count, 16'd3);

    // Basic commit timing from E0
    drive(1, 0, 32'hC800_0000, 0, 1); step();
    drive(0, 0, '0, 1, 1); step();
    drive(0, 0, '0, 0, 0); step(); step(); step();
    check_val("t3_pend_e2", commit_pending, 1'b1);
    step();
    check_val("t3_ctl_e3", ctl_out[31:0], 32'hC800_0000);
    check_val("t3_done_e3", commit_done, 1'b1);
    drive(0, 0, '0, 0, 1); step();
    check_val("t3_done_e4", commit_done, 1'b0);
    repeat (5) step();

    // Request coinciding with vblank_edge waits for the next frame
    drive(1, 2, 32'h0000_00AA, 0, 1); step();
    drive(0, 0, '0, 0, 0); step(); step();
    drive(0, 0, '0, 1, 0); step();
    drive(0, 0, '0, 0, 0); step();
    drive(0, 0, '0, 0, 1); repeat (6) step();
    check_val("t4_ch2_held", ctl_out[95:64], 32'h0);
    check_val("t4_pending", commit_pending, 1'b1);
    vsync(6);
    check_val("t4_ch2_commit", ctl_out[95:64], 32'h0000_00AA);

    // Write during the commit cycle lands in staging only
    drive(1, 3, 32'h3, 0, 1); step();
    drive(0, 0, '0, 1, 1); step();
    drive(0, 0, '0, 0, 0); step(); step(); step();
    drive(1, 3, 32'h5, 0, 0); step();
    rd_ch = 2'd3;
    drive(0, 0, '0, 0, 1); repeat (6) step();
    check_val("t5_active_old", ctl_out[127:96], 32'h3);
    check_val("t5_staging_new", rd_data, 32'h5);
    drive(0, 0, '0, 1, 1); step();
    vsync(6);
    check_val("t5_active_new", ctl_out[127:96], 32'h5);

    // Randomised traffic
    lo_left = 0;
    hi_left = 8;
    for (int i = 0; i < 1500; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_ch = CH_W'($urandom_range(0, NUM_CH-1));
      wr_data = $urandom;
      commit_req = ($urandom_range(0, 9) == 0);
      rd_ch = CH_W'($urandom_range(0, NUM_CH-1));
      if (hi_left > 0) begin
        VGA_VS = 1'b1;
        hi_left--;
        if (hi_left == 0) lo_left = $urandom_range(3, 6);
      end else begin
        VGA_VS = 1'b0;
        lo_left--;
        if (lo_left == 0) hi_left = $urandom_range(4, 30);
      end
      step();
    end

    // Asynchronous reset while a commit is pending
    rd_ch = 2'd3;
    drive(1, 3, 32'hDEAD_BEEF, 0, 1); step(); step();
    drive(0, 0, '0, 1, 1); step();
    drive(0, 0, '0, 0, 1);
    check_val("t1_pend_before", commit_pending, 1'b1);
    #2;
    Reset = 1'b1;
    #1;
    check_val("t1_ctl", ctl_out, '0);
    check_val("t1_frame", frame_count, '0);
    check_val("t1_rd", rd_data, '0);
    check_val("t1_pending", commit_pending, 1'b0);
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    step();

`ifdef FRAME_CTL_EDGE_EN
    // Rising TRIG_BIT across a commit pulses once; recommitting same value does not
    drive(1, 0, 32'h0020_0000, 0, 1); step();
    drive(0, 0, '0, 1, 1); step();
    trig_seen = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, '0, 0, (i < 4) ? 1'b0 : 1'b1);
      step();
      if (i == 4) check_val("t6_trig_e4", trig_pulse, 4'b0001);
      if (i == 5) check_val("t6_trig_e5", trig_pulse, 4'b0000);
    end
    drive(0, 0, '0, 1, 1); step();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, '0, 0, (i < 4) ? 1'b0 : 1'b1);
      step();
      if (trig_pulse != 4'b0000) trig_seen++;
    end
    check_val("t6_no_retrig", trig_seen, 0);
`else
    trig_seen = 0;
    lo_left = trig_seen;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_ctl_regs.md
# frame_ctl_regs

Parametrised, frame-synchronous software-control register bank sitting between the NIOS PIO and the draw engine/audio blocks. It replaces the single directly-decoded 32-bit control word with NUM_CH independently writable staging registers. Staging values are copied atomically into active registers only at the start of vertical blank, so sprite index, position and level never tear mid-frame. It also provides a frame counter and a registered staging readback.

## Interface
- NUM_CH, 4: number of control channels (1..16).
- DATA_W, 32: width of each channel.
- FRAME_CNT_W, 16: frame counter width.
- TRIG_BIT, 21: bit index monitored for edge pulses (only used when FRAME_CTL_EDGE_EN is defined).
- CH_W, derived: $clog2(NUM_CH), minimum 1.

Ports:
- Clk  in  1  system clock (50 MHz); the block's only clock.
- Reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe; one cycle writes one staging register.
- wr_ch  in  CH_W  target channel; values ≥ NUM_CH are ignored.
- wr_data  in  DATA_W  write data.
- commit_req  in  1  one-cycle request to commit staging→active at the next vblank.
- rd_ch  in  CH_W  readback channel select.
- rd_data  out  DATA_W  staging[rd_ch], registered.
- VGA_VS  in  1  active-low vsync from VGA_controller; treated as asynchronous.
- ctl_out  out  NUM_CH*DATA_W  active registers; channel c occupies bits [c*DATA_W +: DATA_W].
- commit_pending  out  1  high in PENDING and COMMIT states.
- commit_done  out  1  one-cycle pulse after the active registers update.
- frame_count  out  FRAME_CNT_W  count of vblank starts; wraps.
- trig_pulse  out  NUM_CH  rising-edge pulse per channel (present only with the macro).

## Operation
- VGA_VS passes through a 2-flop synchroniser (vs_s1, vs_s2) followed by a delay flop vs_d. vblank_edge = vs_d & ~vs_s2.
- Writes: when wr_en is high and wr_ch < NUM_CH, staging[wr_ch] <= wr_data. Writes are accepted in every state.
- The FSM has three states: IDLE, PENDING, COMMIT.
  - IDLE: commit_req moves to PENDING. If vblank_edge arrives in the same cycle, that edge is not used; the commit waits for the next one.
  - PENDING: vblank_edge moves to COMMIT. Further commit_req pulses are ignored (already pending).
  - COMMIT: one cycle. All active[c] <= staging[c]. The next state is IDLE, or PENDING if commit_req is high in this cycle.
- A write in the COMMIT cycle updates staging only. Active receives the pre-write staging value.
- frame_count increments on every vblank_edge, regardless of FSM state, and wraps from all-ones to 0.
- rd_data <= staging[rd_ch] every cycle. For rd_ch ≥ NUM_CH, rd_data is 0.
- Reset at any time, including mid-commit, forces all of the following to 0 asynchronously: staging, active, rd_data, frame_count, commit_done, trig_pulse and the synchroniser flops. It also forces the FSM to IDLE.
- Because the synchroniser and vs_d reset to 0, a VGA_VS held high after reset produces no spurious edge.

## Timing
- Write to staging: visible on rd_data 2 cycles after the wr_en cycle (1 cycle to store, 1 cycle to register the readback).
- Let E0 be the first Clk edge that samples VGA_VS low:
  - vblank_edge is high between E1 and E2.
  - At E2: frame_count increments, and the FSM goes PENDING→COMMIT.
  - At E3: ctl_out updates, commit_done rises (high for exactly one cycle), and the FSM enters IDLE.
- Worst case: ctl_out changes 3 Clk cycles after VGA_VS falls, plus up to 1 cycle of sampling uncertainty.
- VGA_VS must stay low for at least 3 Clk cycles; the 640x480 vsync pulse of 2 lines satisfies this by a wide margin.

## Configuration
- FRAME_CTL_EDGE_EN defined: trig_pulse[c] is registered.
  - It goes high the cycle after a commit (at E4) if active[c][TRIG_BIT] changed 0→1 in that commit, and stays high one cycle.
  - trig_pulse resets to 0.
- FRAME_CTL_EDGE_EN undefined: the trig_pulse port and its logic are absent. TRIG_BIT is unused.

## Test plan
- Reset asserted while commit_pending is high → ctl_out, frame_count, rd_data and commit_pending all become 0 without waiting for a Clk edge.
- Write ch1 = 32'h1234_5678, no commit, 3 vsync pulses → ch1 of ctl_out stays 0, rd_data(rd_ch=1) = 32'h1234_5678, frame_count = 3.
- Write ch0 = 32'hC800_0000, commit_req, then VGA_VS low (E0) → ctl_out[31:0] = 32'hC800_0000 at E3, commit_done high for exactly one cycle.
- commit_req in the same cycle as vblank_edge, with ch2 = 32'hAA → no update on this frame; ch2 of ctl_out = 32'hAA after the following vsync.
- Write ch3 = 32'h5 during the COMMIT cycle, with staging ch3 previously 32'h3 → active ch3 = 32'h3, staging ch3 = 32'h5. A second commit yields 32'h5.
- With FRAME_CTL_EDGE_EN, commit ch0 from 32'h0 to 32'h0020_0000 (bit 21 set) → trig_pulse = 4'b0001 for one cycle at E4. Committing the same value again → no pulse.
